// File: rtl/mem_client_pkg.sv
// Shared types and helpers for the rq/ack memory client.
package mem_client_pkg;

  // Transaction sequencer states; encoding matches the bus_defs convention.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Bus op codes carried on wr_ni (1 = read, 0 = write).
  localparam logic OP_RD = 1'b1;
  localparam logic OP_WR = 1'b0;

  // Width of the REQ-cycle counter; it only ever counts 0..timeout-1.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_client_fifo.sv
// Show-ahead synchronous command FIFO with full/empty flags.
module mem_client_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a freed slot is only visible the cycle after the pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_client.sv
// rq/ack bus initiator: queues commands, runs one bus transaction at a time,
// returns read data or a timeout error as a one-cycle response pulse.
module mem_client
  import mem_client_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_ni,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rq,
  output logic                  wr_ni,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] dataW,
  input  logic                  ack,
  input  logic [DATA_WIDTH-1:0] dataR
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam int unsigned FW = 1 + ADDR_WIDTH + DATA_WIDTH;

  state_t                state;
  state_t                state_nx;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nx;
  logic                  timeout_hit;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop_c;
  logic [FW-1:0]         head;
  logic                  head_wr_ni;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  logic                  rq_nx;
  logic                  wr_ni_nx;
  logic [ADDR_WIDTH-1:0] address_nx;
  logic [DATA_WIDTH-1:0] dataw_nx;
  logic                  rsp_valid_nx;
  logic                  rsp_err_nx;
  logic [DATA_WIDTH-1:0] rsp_rdata_nx;

  mem_client_fifo #(
    .WIDTH (FW),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data ({cmd_wr_ni, cmd_addr, cmd_wdata}),
    .pop       (pop_c),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready   = !fifo_full;
  assign head_wr_ni  = head[FW-1];
  assign head_addr   = head[DATA_WIDTH +: ADDR_WIDTH];
  assign head_wdata  = head[DATA_WIDTH-1:0];
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: start on a queued command, finish on ack or timeout, then one gap cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nx = REQ;
      REQ:     if (ack || timeout_hit) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the bus/response registers; ack takes priority over timeout.
  always_comb begin
    pop_c        = 1'b0;
    cnt_nx       = cnt;
    rq_nx        = rq;
    wr_ni_nx     = wr_ni;
    address_nx   = address;
    dataw_nx     = dataW;
    rsp_valid_nx = 1'b0;
    rsp_err_nx   = rsp_err;
    rsp_rdata_nx = rsp_rdata;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          rq_nx      = 1'b1;
          cnt_nx     = '0;
          wr_ni_nx   = head_wr_ni;
          address_nx = head_addr;
          dataw_nx   = head_wdata;
        end
      end
      REQ: begin
        if (ack) begin
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b0;
          rq_nx        = 1'b0;
          if (wr_ni == OP_RD) rsp_rdata_nx = dataR;
        end else if (timeout_hit) begin
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b1;
          rq_nx        = 1'b0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered bus and response outputs plus the REQ-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rq        <= 1'b0;
      wr_ni     <= OP_RD;
      address   <= '0;
      dataW     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      cnt       <= cnt_nx;
      rq        <= rq_nx;
      wr_ni     <= wr_ni_nx;
      address   <= address_nx;
      dataW     <= dataw_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_err   <= rsp_err_nx;
      rsp_rdata <= rsp_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_client.sv
// Bench for mem_client: RAM responder with configurable ack delay, a
// transaction-level reference model checked every cycle, and directed
// plus randomized command streams.
module tb_mem_client;

  localparam int DW      = 8;
  localparam int AW      = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;
  localparam int NEVER   = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr_ni;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          rq;
  logic          wr_ni;
  logic [AW-1:0] address;
  logic [DW-1:0] dataW;
  logic          ack;
  logic [DW-1:0] dataR;

  mem_client #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CMD_DEPTH  (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr_ni (cmd_wr_ni),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .rq        (rq),
    .wr_ni     (wr_ni),
    .address   (address),
    .dataW     (dataW),
    .ack       (ack),
    .dataR     (dataR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  int total = 0;
  int bad   = 0;

  // Responder RAM and the model's own view of memory contents.
  logic [DW-1:0] ram     [16];
  logic [DW-1:0] mem_ref [16];

  // Responder controls.
  int resp_delay = 0;
  bit resp_rand  = 1'b0;
  bit spur_en    = 1'b0;

  // Reference model state.
  cmd_t          mq[$];
  cmd_t          m_cur;
  bit            m_act;
  bit            m_gap;
  bit            m_err;
  int            m_req_n;
  logic [DW-1:0] m_rdata;

  // Observations used by the literal checks.
  int            rsp_cnt   = 0;
  int            rq_run    = 0;
  int            last_rq_len = 0;
  logic          last_err;
  logic [DW-1:0] last_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_init();
    mq.delete();
    m_act   = 1'b0;
    m_gap   = 1'b0;
    m_err   = 1'b0;
    m_req_n = 0;
    m_rdata = '0;
    rq_run  = 0;
  endtask

  // RAM responder: acks after resp_delay REQ cycles, optional spurious acks while idle.
  initial begin
    int wcnt;
    int cur_delay;
    ack = 1'b0;
    dataR = '0;
    wcnt = 0;
    cur_delay = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rq && !reset) begin
        if (wcnt == 0)
          cur_delay = resp_rand ? (($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 3)))
                                : resp_delay;
        if (wcnt == cur_delay) begin
          ack = 1'b1;
          if (wr_ni) dataR = ram[address];
          else begin
            ram[address] = dataW;
            dataR = DW'($urandom);
          end
        end else begin
          ack = 1'b0;
          dataR = DW'($urandom);
        end
        wcnt++;
      end else begin
        wcnt = 0;
        ack = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
        dataR = DW'($urandom);
      end
    end
  end

  // Per-cycle compare against the transaction model, then advance the model.
  initial begin
    bit acc;
    bit ng;
    m_init();
    forever begin
      @(negedge clk);
      if (reset) begin
        m_init();
        continue;
      end
      chk("rq", rq, m_act);
      chk("cmd_ready", cmd_ready, (mq.size() < DEPTH));
      chk("rsp_valid", rsp_valid, m_gap);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      if (m_act) begin
        chk("wr_ni", wr_ni, m_cur.wr);
        chk("address", address, m_cur.a);
        chk("dataW", dataW, m_cur.d);
      end
      if (m_gap) chk("rsp_err", rsp_err, m_err);

      if (rsp_valid) begin
        rsp_cnt++;
        last_err   = rsp_err;
        last_rdata = rsp_rdata;
      end
      if (rq) rq_run++;
      else if (rq_run != 0) begin
        last_rq_len = rq_run;
        rq_run = 0;
      end

      acc = cmd_valid && (mq.size() < DEPTH);
      ng  = 1'b0;
      if (m_act) begin
        if (ack) begin
          ng = 1'b1;
          m_err = 1'b0;
          if (m_cur.wr) m_rdata = mem_ref[m_cur.a];
          else mem_ref[m_cur.a] = m_cur.d;
          m_act = 1'b0;
        end else if (m_req_n == TIMEOUT) begin
          ng = 1'b1;
          m_err = 1'b1;
          m_act = 1'b0;
        end else begin
          m_req_n++;
        end
      end else if (!m_gap && mq.size() > 0) begin
        m_cur   = mq.pop_front();
        m_act   = 1'b1;
        m_req_n = 1;
      end
      if (acc) mq.push_back('{cmd_wr_ni, cmd_addr, cmd_wdata});
      m_gap = ng;
    end
  end

  // Offer one command until accepted; reports how many cycles it stalled.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int stalls);
    bit taken;
    stalls    = 0;
    taken     = 1'b0;
    cmd_valid = 1'b1;
    cmd_wr_ni = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 300 && !taken; i++) begin
      @(negedge clk);
      taken = cmd_ready;
      @(posedge clk);
      #1;
      if (!taken) stalls++;
    end
    if (!taken) chk("cmd_accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait until the model has no queued, active or responding transaction.
  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (mq.size() == 0) && !m_act && !m_gap;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int rc0;
    int stall_seen;
    int waited;

    for (int i = 0; i < 16; i++) begin
      ram[i]     = DW'(i * 29 + 5);
      mem_ref[i] = DW'(i * 29 + 5);
    end
    ram[7]     = 8'h3C;
    mem_ref[7] = 8'h3C;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr_ni = 1'b1;
    cmd_addr  = '0;
    cmd_wdata = '0;
    idle_cycles(3);
    @(negedge clk);
    chk("rst_rq", rq, 1'b0);
    chk("rst_wr_ni", wr_ni, 1'b1);
    chk("rst_address", address, 0);
    chk("rst_dataW", dataW, 0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(2);

    // Write 0xA5 @3 then read it back, zero ack delay.
    resp_delay = 0;
    rc0 = rsp_cnt;
    send_cmd(1'b0, 4'd3, 8'hA5, st);
    send_cmd(1'b1, 4'd3, 8'h00, st);
    wait_idle();
    chk("wr_rd_count", rsp_cnt - rc0, 2);
    chk("wr_rd_err", last_err, 1'b0);
    chk("wr_rd_data", last_rdata, 8'hA5);

    // Ack delay 5 on a preloaded read.
    resp_delay = 5;
    send_cmd(1'b1, 4'd7, 8'h00, st);
    wait_idle();
    chk("delay5_rq_len", last_rq_len, 6);
    chk("delay5_data", last_rdata, 8'h3C);

    // No ack at all: abort after TIMEOUT cycles of rq.
    resp_delay = NEVER;
    rc0 = rsp_cnt;
    send_cmd(1'b1, 4'd2, 8'h00, st);
    wait_idle();
    chk("timeout_rq_len", last_rq_len, 32);
    chk("timeout_err", last_err, 1'b1);
    chk("timeout_count", rsp_cnt - rc0, 1);
    chk("timeout_data_kept", last_rdata, 8'h3C);

    // Six back-to-back commands into a four-entry FIFO.
    resp_delay = 2;
    rc0 = rsp_cnt;
    stall_seen = 0;
    for (int i = 0; i < 6; i++) begin
      send_cmd(1'(i % 2), 4'(i + 8), 8'(8'h10 + i), waited);
      stall_seen += waited;
    end
    wait_idle();
    chk("b2b_stalled", (stall_seen > 0), 1'b1);
    chk("b2b_count", rsp_cnt - rc0, 6);

    // Spurious acks while nothing is outstanding.
    spur_en = 1'b1;
    rc0 = rsp_cnt;
    idle_cycles(20);
    chk("spur_no_rsp", rsp_cnt - rc0, 0);

    // Reset in the middle of a read with more commands queued.
    spur_en = 1'b0;
    resp_delay = NEVER;
    send_cmd(1'b1, 4'd5, 8'h00, st);
    send_cmd(1'b0, 4'd6, 8'h11, st);
    send_cmd(1'b0, 4'd7, 8'h22, st);
    waited = 0;
    for (int i = 0; i < 50 && !rq; i++) idle_cycles(1);
    chk("pre_reset_rq", rq, 1'b1);
    idle_cycles(2);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_rq", rq, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rc0 = rsp_cnt;
    idle_cycles(10);
    chk("post_reset_no_rsp", rsp_cnt - rc0, 0);

    // Randomized traffic with random ack delays, timeouts and spurious acks.
    resp_rand = 1'b1;
    spur_en   = 1'b1;
    rc0 = rsp_cnt;
    for (int n = 0; n < 60; n++) begin
      send_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), st);
      idle_cycles($urandom_range(0, 4));
    end
    wait_idle();
    chk("rand_count", rsp_cnt - rc0, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
